// File: rtl/spirose_pkg.sv
// rtl/spirose_pkg.sv - shared constants and FSM state type for the driver config writer
`timescale 1ns/1ps
package spirose_pkg;

    localparam int CONFIG_W               = 48;
    localparam int FCWRTEN_CLKS_DEFAULT   = 15;
    localparam int WRTFC_LAT_CLKS_DEFAULT = 5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GRANT,
        FCWRTEN,
        GAP,
        WRTFC,
        DONE
    } cfg_state_t;

endpackage

// File: rtl/driver_config_writer_if.sv
// rtl/driver_config_writer_if.sv - shared LED driver serial bus plus request/grant handshake
`timescale 1ns/1ps
interface driver_config_writer_if;

    logic bus_req;
    logic bus_grant;
    logic drv_sclk;
    logic drv_sin;
    logic drv_lat;

    modport master (output bus_req, drv_sclk, drv_sin, drv_lat, input bus_grant);
    modport slave  (input bus_req, drv_sclk, drv_sin, drv_lat, output bus_grant);

endinterface

// File: rtl/config_cdc_capture.sv
// rtl/config_cdc_capture.sv - flag synchroniser and double-sampled config word with stability detect
`timescale 1ns/1ps
module config_cdc_capture
    import spirose_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic [CONFIG_W-1:0] config_in,
    input  logic                config_flag,
    output logic                flag_sync,
    output logic [CONFIG_W-1:0] cap_b,
    output logic                stable
);

    logic                flag_meta;
    logic [CONFIG_W-1:0] cap_a;
    logic [1:0]          match_cnt;

    // The word is only trusted once two consecutive samples agree twice in a row.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            flag_meta <= 1'b0;
            flag_sync <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
            match_cnt <= 2'd0;
        end else begin
            flag_meta <= config_flag;
            flag_sync <= flag_meta;
            cap_a     <= config_in;
            cap_b     <= cap_a;
            if (cap_a != cap_b)
                match_cnt <= 2'd0;
            else if (match_cnt != 2'd2)
                match_cnt <= match_cnt + 2'd1;
        end
    end

    assign stable = (match_cnt == 2'd2);

endmodule

// File: rtl/driver_config_writer.sv
// rtl/driver_config_writer.sv - writes the captured config into the LED drivers' function-control register
`timescale 1ns/1ps
module driver_config_writer
    import spirose_pkg::*;
#(
    parameter int                  NB_DRIVERS     = 1,
    parameter int                  FCWRTEN_CLKS   = FCWRTEN_CLKS_DEFAULT,
    parameter int                  WRTFC_LAT_CLKS = WRTFC_LAT_CLKS_DEFAULT,
    parameter logic [CONFIG_W-1:0] DEFAULT_CONFIG = '0
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [CONFIG_W-1:0]          config_in,
    input  logic                         config_flag,
    driver_config_writer_if.master       bus,
    output logic                         cfg_busy,
    output logic                         cfg_done
);

    localparam int TOTAL_BITS = CONFIG_W * NB_DRIVERS;
    localparam int BIT_W      = $clog2(TOTAL_BITS + 1);
    localparam int FC_W       = $clog2(FCWRTEN_CLKS + 1);
    localparam int CNT_W      = (BIT_W > FC_W) ? BIT_W : FC_W;
    localparam logic [CNT_W-1:0] FC_LAST   = CNT_W'(FCWRTEN_CLKS - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(TOTAL_BITS - 1);
    localparam logic [CNT_W-1:0] LAT_FIRST = CNT_W'(TOTAL_BITS - WRTFC_LAT_CLKS);

    cfg_state_t          state, state_nxt;
    logic                phase;
    logic [CNT_W-1:0]    cnt;
    logic [CONFIG_W-1:0] shadow, sreg, last_applied;
    logic                flag_sync, stable;
    logic [CONFIG_W-1:0] cap_b;

    config_cdc_capture u_cdc (
        .clk         (clk),
        .nrst        (nrst),
        .config_in   (config_in),
        .config_flag (config_flag),
        .flag_sync   (flag_sync),
        .cap_b       (cap_b),
        .stable      (stable)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // phase 0 drives data/latch with sclk low, phase 1 raises sclk.
    always_comb begin
        state_nxt    = state;
        bus.bus_req  = 1'b0;
        bus.drv_sclk = 1'b0;
        bus.drv_sin  = 1'b0;
        bus.drv_lat  = 1'b0;
        cfg_busy     = 1'b0;
        cfg_done     = 1'b0;
        case (state)
            IDLE: begin
                if (flag_sync && stable && (cap_b != last_applied))
                    state_nxt = WAIT_GRANT;
            end
            WAIT_GRANT: begin
                bus.bus_req = 1'b1;
                cfg_busy    = 1'b1;
                if (bus.bus_grant) state_nxt = FCWRTEN;
            end
            FCWRTEN: begin
                bus.bus_req  = 1'b1;
                cfg_busy     = 1'b1;
                bus.drv_sclk = phase;
                bus.drv_lat  = 1'b1;
                if (phase && (cnt == FC_LAST)) state_nxt = GAP;
            end
            GAP: begin
                bus.bus_req = 1'b1;
                cfg_busy    = 1'b1;
                if (phase) state_nxt = WRTFC;
            end
            WRTFC: begin
                bus.bus_req  = 1'b1;
                cfg_busy     = 1'b1;
                bus.drv_sclk = phase;
                bus.drv_sin  = sreg[CONFIG_W-1];
                bus.drv_lat  = (cnt >= LAT_FIRST);
                if (phase && (cnt == BIT_LAST)) state_nxt = DONE;
            end
            DONE: begin
                cfg_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The shift register rotates so the same word repeats for every chained driver.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase        <= 1'b0;
            cnt          <= '0;
            shadow       <= '0;
            sreg         <= '0;
            last_applied <= DEFAULT_CONFIG;
        end else begin
            if (state inside {FCWRTEN, GAP, WRTFC}) phase <= ~phase;
            else                                    phase <= 1'b0;
            if (state != state_nxt) cnt <= '0;
            else if (phase)         cnt <= cnt + CNT_W'(1);
            if ((state == IDLE) && (state_nxt == WAIT_GRANT)) shadow <= cap_b;
            if (state == GAP)
                sreg <= shadow;
            else if ((state == WRTFC) && phase)
                sreg <= {sreg[CONFIG_W-2:0], sreg[CONFIG_W-1]};
            if (state == DONE) last_applied <= shadow;
        end
    end

endmodule

// File: tb/tb_driver_config_writer.sv
// tb/tb_driver_config_writer.sv - scoreboard bench for driver_config_writer (1 and 3 drivers)
`timescale 1ns/1ps
module tb_driver_config_writer;
    import spirose_pkg::*;

    typedef struct packed { logic sin; logic lat; } rise_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [47:0] cfg1 = '0, cfg3 = '0;
    logic        flag1 = 1'b0, flag3 = 1'b0;
    logic        busy1, done1, busy3, done3;
    logic        prev1 = 1'b0, prev3 = 1'b0;
    int          rise1 = 0, rise3 = 0;
    int          checks = 0, errors = 0;
    rise_t       exp1[$], exp3[$];

    always #5 clk = ~clk;

    driver_config_writer_if bus1 ();
    driver_config_writer_if bus3 ();

    driver_config_writer #(.NB_DRIVERS(1)) dut (
        .clk(clk), .nrst(nrst), .config_in(cfg1), .config_flag(flag1),
        .bus(bus1.master), .cfg_busy(busy1), .cfg_done(done1));

    driver_config_writer #(.NB_DRIVERS(3)) dut3 (
        .clk(clk), .nrst(nrst), .config_in(cfg3), .config_flag(flag3),
        .bus(bus3.master), .cfg_busy(busy3), .cfg_done(done3));

    // Scoreboard: every drv_sclk rise pops the expected (sin, lat) pair.
    always @(negedge clk) begin
        rise_t e;
        if (bus1.drv_sclk && !prev1) begin
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL rise1_unexpected: rise %0d sin=%b lat=%b, required no rise", rise1, bus1.drv_sin, bus1.drv_lat);
            end else begin
                e = exp1.pop_front();
                if ({bus1.drv_sin, bus1.drv_lat} !== {e.sin, e.lat}) begin
                    errors++;
                    $display("FAIL rise1_%0d: sin,lat=%b%b required %b%b", rise1, bus1.drv_sin, bus1.drv_lat, e.sin, e.lat);
                end
            end
            rise1++;
        end
        prev1 = bus1.drv_sclk;
        if (bus3.drv_sclk && !prev3) begin
            checks++;
            if (exp3.size() == 0) begin
                errors++;
                $display("FAIL rise3_unexpected: rise %0d sin=%b lat=%b, required no rise", rise3, bus3.drv_sin, bus3.drv_lat);
            end else begin
                e = exp3.pop_front();
                if ({bus3.drv_sin, bus3.drv_lat} !== {e.sin, e.lat}) begin
                    errors++;
                    $display("FAIL rise3_%0d: sin,lat=%b%b required %b%b", rise3, bus3.drv_sin, bus3.drv_lat, e.sin, e.lat);
                end
            end
            rise3++;
        end
        prev3 = bus3.drv_sclk;
    end

    task automatic push_exp(input logic [47:0] v, input int nb, input bit three);
        rise_t e;
        for (int i = 0; i < 15; i++) begin
            e.sin = 1'b0; e.lat = 1'b1;
            if (three) exp3.push_back(e); else exp1.push_back(e);
        end
        for (int i = 0; i < 48 * nb; i++) begin
            e.sin = v[47 - (i % 48)];
            e.lat = (i >= 48 * nb - 5);
            if (three) exp3.push_back(e); else exp1.push_back(e);
        end
    endtask

    task automatic do_write1(input logic [47:0] v, input int gdelay, input bit drop, input string name);
        int n;
        bit seen;
        push_exp(v, 1, 1'b0);
        seen = 1'b0;
        for (n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = bus1.bus_req;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_req: bus_req=0 after 40 clks, required 1", name);
            exp1.delete();
            return;
        end
        for (int i = 0; i < gdelay; i++) begin
            @(negedge clk);
            checks++;
            if ({bus1.bus_req, busy1, bus1.drv_sclk, bus1.drv_sin, bus1.drv_lat, done1} !== 6'b110000) begin
                errors++;
                $display("FAIL %s_wait: req,busy,sclk,sin,lat,done=%b required 110000", name,
                         {bus1.bus_req, busy1, bus1.drv_sclk, bus1.drv_sin, bus1.drv_lat, done1});
            end
        end
        bus1.bus_grant = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = done1;
            if (drop && n == 10) bus1.bus_grant = 1'b0;
            if (n == 31 || n == 32) begin
                checks++;
                if ({bus1.bus_req, bus1.drv_sclk, bus1.drv_lat} !== 3'b100) begin
                    errors++;
                    $display("FAIL %s_gap: req,sclk,lat=%b required 100", name, {bus1.bus_req, bus1.drv_sclk, bus1.drv_lat});
                end
            end
        end
        checks++;
        if (!seen || n != 129) begin
            errors++;
            $display("FAIL %s_latency: cfg_done after %0d clks (seen=%0d), required 129", name, n, seen);
        end
        checks++;
        if ({bus1.bus_req, busy1, bus1.drv_sclk, bus1.drv_sin, bus1.drv_lat} !== 5'b00000) begin
            errors++;
            $display("FAIL %s_done_outs: req,busy,sclk,sin,lat=%b required 00000", name,
                     {bus1.bus_req, busy1, bus1.drv_sclk, bus1.drv_sin, bus1.drv_lat});
        end
        bus1.bus_grant = 1'b0;
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: cfg_done=%b required 0", name, done1);
        end
        checks++;
        if (exp1.size() != 0) begin
            errors++;
            $display("FAIL %s_bits: %0d rises missing, required 0", name, exp1.size());
        end
    endtask

    task automatic idle_hold(input int clks, input string name);
        for (int i = 0; i < clks; i++) begin
            @(negedge clk);
            checks++;
            if ({bus1.bus_req, busy1} !== 2'b00) begin
                errors++;
                $display("FAIL %s_idle: req,busy=%b required 00", name, {bus1.bus_req, busy1});
            end
        end
    endtask

    task automatic test_reset();
        #1 nrst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus1.bus_req, bus1.drv_sclk, bus1.drv_sin, bus1.drv_lat, busy1, done1,
             bus3.bus_req, bus3.drv_sclk, bus3.drv_sin, bus3.drv_lat, busy3, done3} !== 12'b0) begin
            errors++;
            $display("FAIL reset_outs: dut1/dut3 outputs not all 0");
        end
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus1.bus_req, busy1, done1, bus3.bus_req, busy3, done3} !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle: req/busy/done=%b required 000000",
                     {bus1.bus_req, busy1, done1, bus3.bus_req, busy3, done3});
        end
    endtask

    task automatic test_first_write();
        cfg1 = 48'h123456789ABC;
        flag1 = 1'b1;
        do_write1(48'h123456789ABC, 4, 1'b0, "t1");
    endtask

    task automatic test_no_repeat();
        idle_hold(60, "t2_same");
        cfg1 = 48'hFFFF00000001;
        do_write1(48'hFFFF00000001, 2, 1'b0, "t2_new");
        idle_hold(40, "t2_after");
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cfg1 = (i % 2 == 0) ? 48'h0F0F0F0F0F0F : 48'hF0F0F0F0F0F0;
            checks++;
            if (bus1.bus_req !== 1'b0) begin
                errors++;
                $display("FAIL t3_toggle_req: bus_req=%b at toggle %0d required 0", bus1.bus_req, i);
            end
        end
        cfg1 = 48'hA5A55A5AC3C3;
        do_write1(48'hA5A55A5AC3C3, 2, 1'b1, "t3");
    endtask

    task automatic test_long_wait();
        cfg1 = 48'h000000000001;
        do_write1(48'h000000000001, 1000, 1'b0, "t4");
    endtask

    task automatic test_reset_mid();
        logic [47:0] v;
        bit seen;
        v = 48'hDEADBEEFCAFE;
        cfg1 = v;
        push_exp(v, 1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus1.bus_req;
        end
        bus1.bus_grant = 1'b1;
        repeat (73) @(posedge clk);
        #1;
        checks++;
        if ({bus1.bus_req, busy1, bus1.drv_sclk, bus1.drv_sin, bus1.drv_lat} !== {3'b110, v[27], 1'b0}) begin
            errors++;
            $display("FAIL t5_bit20: req,busy,sclk,sin,lat=%b required %b",
                     {bus1.bus_req, busy1, bus1.drv_sclk, bus1.drv_sin, bus1.drv_lat}, {3'b110, v[27], 1'b0});
        end
        nrst = 1'b0;
        #1;
        checks++;
        if ({bus1.bus_req, busy1, bus1.drv_sclk, bus1.drv_sin, bus1.drv_lat, done1} !== 6'b0) begin
            errors++;
            $display("FAIL t5_async_reset: outs=%b required 000000",
                     {bus1.bus_req, busy1, bus1.drv_sclk, bus1.drv_sin, bus1.drv_lat, done1});
        end
        checks++;
        if (exp1.size() != 28) begin
            errors++;
            $display("FAIL t5_partial: %0d rises left, required 28", exp1.size());
        end
        exp1.delete();
        bus1.bus_grant = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        do_write1(v, 3, 1'b0, "t5_rewrite");
    endtask

    task automatic test_nb3();
        int n;
        bit seen;
        cfg3 = 48'h5A5A1234F00F;
        flag3 = 1'b1;
        push_exp(48'h5A5A1234F00F, 3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus3.bus_req;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL t6_req: bus_req=0 after 40 clks, required 1");
        end
        @(negedge clk);
        bus3.bus_grant = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 500) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = done3;
        end
        checks++;
        if (!seen || n != 321) begin
            errors++;
            $display("FAIL t6_latency: cfg_done after %0d clks (seen=%0d), required 321", n, seen);
        end
        bus3.bus_grant = 1'b0;
        @(negedge clk);
        checks++;
        if (exp3.size() != 0 || rise3 != 159) begin
            errors++;
            $display("FAIL t6_bits: %0d rises left, %0d rises seen, required 0 and 159", exp3.size(), rise3);
        end
    endtask

    initial begin
        bus1.bus_grant = 1'b0;
        bus3.bus_grant = 1'b0;
        test_reset();
        test_first_write();
        test_no_repeat();
        test_toggle();
        test_long_wait();
        test_reset_mid();
        test_nb3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/driver_config_writer.md
Name: driver_config_writer

Overview:
- Consumes the 48-bit driver configuration produced by the SPI slave (sck domain) and writes it into the daisy-chained LED drivers' function-control register from the system clock domain.
- Handles the clock-domain crossing and arbitrates the shared driver serial bus with the pixel streamer using a request/grant handshake.
- Emits the FCWRTEN + WRTFC latch sequence.

Parameters:
- NB_DRIVERS, 1: number of daisy-chained drivers; the config word is shifted NB_DRIVERS times.
- FCWRTEN_CLKS, 15: drv_sclk periods with drv_lat high for the FCWRTEN command.
- WRTFC_LAT_CLKS, 5: trailing drv_sclk periods of the data shift during which drv_lat is high.
- DEFAULT_CONFIG, 48'h0: value of the "last applied" register at reset.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- config_in  in  48  configuration word from SPI slave (sck domain, quasi-static)
- config_flag  in  1  new-configuration flag from SPI slave (sck domain, level, sticky)
- bus_grant  in  1  pixel streamer has released the driver bus
- bus_req  out  1  request for the driver bus
- drv_sclk  out  1  driver serial clock
- drv_sin  out  1  driver serial data
- drv_lat  out  1  driver latch
- cfg_busy  out  1  write sequence in progress
- cfg_done  out  1  one-cycle pulse when a write completes

Behaviour:
- Reset values: bus_req=0, drv_sclk=0, drv_sin=0, drv_lat=0, cfg_busy=0, cfg_done=0; last_applied=DEFAULT_CONFIG; state IDLE.
- CDC:
  - config_flag passes through a 2-FF synchroniser.
  - config_in is sampled into cap_a every clk, then into cap_b. The sample is stable when cap_a==cap_b for 2 consecutive clks (stable counter resets on any mismatch).
- Trigger: in IDLE, when flag_sync=1 AND the sample is stable AND cap_b != last_applied → latch shadow=cap_b, go to WAIT_GRANT. Equal values never trigger, so the sticky flag does not cause repeated writes.
- WAIT_GRANT: bus_req=1, cfg_busy=1. Wait indefinitely. On bus_grant=1 → FCWRTEN the next clk.
- Bit timing: one drv_sclk period = 2 clks.
  - Phase 0: drv_sclk=0; drv_sin and drv_lat are updated.
  - Phase 1: drv_sclk=1.
  - Data is therefore stable a full clk before each rising edge.
- FCWRTEN state: FCWRTEN_CLKS periods with drv_sin=0 and drv_lat=1 throughout. Then 1 period with drv_lat=0 and drv_sclk idle (GAP) → WRTFC.
- WRTFC state:
  - Shift 48*NB_DRIVERS bits: shadow MSB first, repeated per driver; bit counter width is clog2(48*NB_DRIVERS+1).
  - drv_lat=1 for the final WRTFC_LAT_CLKS periods, asserted in phase 0 of bit index 48*NB_DRIVERS-WRTFC_LAT_CLKS.
  - drv_lat falls in phase 0 after the last period; drv_sclk stays 0.
- DONE (1 clk): last_applied<=shadow, cfg_done=1, bus_req=0, cfg_busy=0, drv_sin=0 → IDLE.
- Total sequence from grant to cfg_done: 2*(FCWRTEN_CLKS+1+48*NB_DRIVERS)+1 clks.
- bus_grant deasserted mid-sequence: ignored. The streamer must hold grant while bus_req=1; the sequence is never aborted.
- config_in changing mid-sequence: ignored, since shadow is held. A new differing value triggers a fresh write after returning to IDLE.
- flag_sync falling: ignored once out of IDLE.
- nrst asserted mid-sequence: all outputs return to reset values immediately. A partial driver write is not recovered; last_applied returns to DEFAULT_CONFIG, so the config is rewritten after reset if the flag is still high.

Decomposition:
- Shared package spirose_pkg: CONFIG_W=48, FSM state enum (IDLE, WAIT_GRANT, FCWRTEN, GAP, WRTFC, DONE), FCWRTEN/WRTFC default lengths.
- Natural sub-module: config_cdc_capture, containing the flag synchroniser, the bus double-sample and the stability counter, and outputting a validated cap_b plus a stable strobe.

Test Plan:
1. Reset, then config_in=48'h123456789ABC with config_flag=1; grant 4 clks after bus_req.
   - Expect 15 drv_sclk rises with lat=1 and sin=0, a 1-period gap, then 48 bits MSB-first matching 0x123456789ABC.
   - Expect lat high on exactly the last 5 rises, then cfg_done once, 2*(15+1+48)+1=129 clks after grant.
2. Same config held with flag high after completion.
   - Expect no further bus_req.
   - Change to 48'hFFFF00000001: exactly one new write.
3. Toggle config_in every clk while flag=1.
   - Expect no trigger until the value is held ≥2 clks, then a write of the held value.
4. Hold bus_grant=0 for 1000 clks after request.
   - Expect bus_req=1, cfg_busy=1, drv_* static 0 throughout.
   - Then grant: normal sequence.
5. Assert nrst during WRTFC bit 20.
   - Expect all outputs 0 in the same cycle.
   - After release with the flag still high: a complete rewrite.
6. NB_DRIVERS=3.
   - Expect 144 data bits (the word repeated 3×) and lat high on rises 140-144.
